npu_instr_sequencer: RTL

Instruction sequencer for the NPU. It holds a small instruction memory loaded by the host and walks a program counter from a start address. It issues one instruction at a time to the instruction decoder, stalling on MVU and MFU completion handshakes. It stops at `END_CHAIN` and pulses `done`. It sits between the host/DRAM loader and `instruction_decoder`, and is the only driver of the decoder's `instruction` input.

---
 rtl/npu_instr_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/npu_instr_sequencer.sv
// Instruction sequencer: host-loaded instruction memory, PC walk, MVU/MFU stall handshakes.
// Optional NPU_SEQ_LOOP_EN adds loop_count to replay the program before signalling done.
`timescale 1ns/1ps
module npu_instr_sequencer #(
  parameter int INSTR_WIDTH = 20,
  parameter int IMEM_AWIDTH = 6,
  parameter int IMEM_DEPTH  = 1 << IMEM_AWIDTH
) (
  input  logic                   clk,
  input  logic                   reset_npu,
  input  logic                   imem_wr_en,
  input  logic [IMEM_AWIDTH-1:0] imem_wr_addr,
  input  logic [INSTR_WIDTH-1:0] imem_wr_data,
  input  logic                   start,
  input  logic [IMEM_AWIDTH-1:0] start_pc,
`ifdef NPU_SEQ_LOOP_EN
  input  logic [7:0]             loop_count,
`endif
  input  logic                   mvu_done,
  input  logic                   mfu_done,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [IMEM_AWIDTH-1:0] pc
);

  // END_CHAIN with a zero payload keeps the decoder's units parked.
  localparam logic [INSTR_WIDTH-1:0] IDLE_WORD = {4'd11, {(INSTR_WIDTH-4){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_MVU,
    S_WAIT_MFU,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_NEXT,
    C_MVU,
    C_MFU,
    C_END,
    C_ILL
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd6:               classify = C_NEXT;
      4'd3:                                 classify = C_MVU;
      4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10:  classify = C_MFU;
      4'd11:                                classify = C_END;
      default:                              classify = C_ILL;
    endcase
  endfunction

  state_e                 state, state_d;
  op_class_e              op_cls;
  logic                   pc_step;
  logic                   pc_reload;
  logic                   loop_again;
  logic [IMEM_AWIDTH-1:0] reload_pc;
  logic                   mvu_seen;
  logic                   mfu_seen;
  logic                   start_acc;

  logic [INSTR_WIDTH-1:0] imem [IMEM_DEPTH];

  assign op_cls    = classify(instruction[INSTR_WIDTH-1 -: 4]);
  assign start_acc = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

`ifdef NPU_SEQ_LOOP_EN
  logic [7:0]             loop_rem;
  logic [IMEM_AWIDTH-1:0] start_pc_q;

  // loop_rem counts passes still owed after the current one.
  always_ff @(posedge clk) begin
    if (reset_npu) begin
      loop_rem   <= 8'd0;
      start_pc_q <= '0;
    end else if (start_acc) begin
      loop_rem   <= (loop_count == 8'd0) ? 8'd0 : loop_count - 8'd1;
      start_pc_q <= start_pc;
    end else if (pc_reload) begin
      loop_rem   <= loop_rem - 8'd1;
    end
  end

  assign loop_again = (loop_rem != 8'd0);
  assign reload_pc  = start_pc_q;
`else
  assign loop_again = 1'b0;
  assign reload_pc  = pc;
`endif

  always_ff @(posedge clk) begin
    if (reset_npu) state <= S_IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d   = state;
    pc_step   = 1'b0;
    pc_reload = 1'b0;
    case (state)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        case (op_cls)
          C_NEXT: begin
            state_d = S_FETCH;
            pc_step = 1'b1;
          end
          C_MVU:  state_d = S_WAIT_MVU;
          C_MFU:  state_d = S_WAIT_MFU;
          C_END: begin
            if (loop_again) begin
              state_d   = S_FETCH;
              pc_reload = 1'b1;
            end else begin
              state_d   = S_DONE;
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_WAIT_MVU: begin
        if (mvu_seen || mvu_done) begin
          state_d = S_FETCH;
          pc_step = 1'b1;
        end
      end
      S_WAIT_MFU: begin
        if (mfu_seen || mfu_done) begin
          state_d = S_FETCH;
          pc_step = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host loads only while idle; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (imem_wr_en && (state == S_IDLE)) imem[imem_wr_addr] <= imem_wr_data;
  end

  // Width of pc makes the increment wrap modulo IMEM_DEPTH.
  always_ff @(posedge clk) begin
    if (reset_npu)      pc <= '0;
    else if (start_acc) pc <= start_pc;
    else if (pc_reload) pc <= reload_pc;
    else if (pc_step)   pc <= pc + IMEM_AWIDTH'(1);
  end

  // The instruction register is the memory's read register, so FETCH->ISSUE is one cycle.
  always_ff @(posedge clk) begin
    if (reset_npu) begin
      instruction <= IDLE_WORD;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= (state == S_FETCH);
      if (state == S_FETCH)       instruction <= imem[pc];
      else if (state_d == S_DONE) instruction <= IDLE_WORD;
    end
  end

  // A done arriving in the ISSUE cycle of its waiter wins over the clear.
  always_ff @(posedge clk) begin
    if (reset_npu) begin
      error    <= 1'b0;
      mvu_seen <= 1'b0;
      mfu_seen <= 1'b0;
    end else begin
      if (start_acc)                                  error <= 1'b0;
      else if ((state == S_ISSUE) && (op_cls == C_ILL)) error <= 1'b1;

      if (state != S_IDLE) begin
        if (mvu_done)                                       mvu_seen <= 1'b1;
        else if ((state == S_ISSUE) && (op_cls == C_MVU))   mvu_seen <= 1'b0;
        if (mfu_done)                                       mfu_seen <= 1'b1;
        else if ((state == S_ISSUE) && (op_cls == C_MFU))   mfu_seen <= 1'b0;
      end
    end
  end

endmodule
